// File: rtl/tia_horiz_counter.sv
// TIA horizontal timing: phi1/phi2 phase generator, 57-state polynomial line
// counter, horizontal event decodes and the HSYNC/HBLANK level latches.
module tia_horiz_counter (
   input  logic       clk,
   input  logic       rl,
   input  logic       rsyn,
   input  logic       hmove,
   output logic       phi1,
   output logic       phi2,
   output logic [5:0] count,
   output logic       shb,
   output logic       shs,
   output logic       rhs,
   output logic       rcb,
   output logic       rhb,
   output logic       lrhb,
   output logic       cnt,
   output logic       res,
   output logic       hsync,
   output logic       hblank
);

   localparam int unsigned CW = 6;
   localparam int unsigned PW = 2;

   // One step of the line polynomial counter.
   function automatic logic [CW-1:0] lfsr_step(input logic [CW-1:0] c);
      return {c[CW-2:0], ~(c[CW-1] ^ c[CW-2])};
   endfunction

   // Code reached n steps after the all-zero reset code.
   function automatic logic [CW-1:0] code_at(input int unsigned n);
      logic [CW-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < n; i++) c = lfsr_step(c);
      return c;
   endfunction

   localparam logic [CW-1:0] C_SHB  = code_at(0);
   localparam logic [CW-1:0] C_SHS  = code_at(4);
   localparam logic [CW-1:0] C_RHS  = code_at(8);
   localparam logic [CW-1:0] C_RCB  = code_at(12);
   localparam logic [CW-1:0] C_RHB  = code_at(16);
   localparam logic [CW-1:0] C_LRHB = code_at(18);
   localparam logic [CW-1:0] C_CNT  = code_at(36);
   localparam logic [CW-1:0] C_RES  = code_at(56);

   logic [PW-1:0] ph;
   logic          late;

   // Event decodes straight off the registered counter.
   assign shb  = (count == C_SHB);
   assign shs  = (count == C_SHS);
   assign rhs  = (count == C_RHS);
   assign rcb  = (count == C_RCB);
   assign rhb  = (count == C_RHB);
   assign lrhb = (count == C_LRHB);
   assign cnt  = (count == C_CNT);
   assign res  = (count == C_RES);

   always_ff @(posedge clk) begin
      if (!rl) begin
         ph     <= '0;
         count  <= '0;
         phi1   <= 1'b0;
         phi2   <= 1'b0;
         hsync  <= 1'b0;
         hblank <= 1'b1;
         late   <= 1'b0;
      end else if (rsyn) begin
         ph     <= '0;
         count  <= '0;
         phi1   <= 1'b0;
         phi2   <= 1'b0;
         hsync  <= 1'b0;
         hblank <= 1'b1;
         late   <= late | hmove;
      end else begin
         ph   <= ph + PW'(1);
         phi1 <= (ph == PW'(0));
         phi2 <= (ph == PW'(2));

         // Advance at the end of phi2; the last code of the line wraps to zero.
         if (ph == PW'(3))
            count <= (count == C_RES) ? '0 : lfsr_step(count);

         // Levels latch at the end of phi1.
         if (ph == PW'(1)) begin
            if (count == C_SHB) hblank <= 1'b1;
            if (count == C_SHS) hsync  <= 1'b1;
            if (count == C_RHS) hsync  <= 1'b0;
            if (count == C_RHB && !late && !hmove) hblank <= 1'b0;
            if (count == C_LRHB) hblank <= 1'b0;
         end

         // A set from hmove beats the late-HBLANK clear on the same edge.
         if (hmove)
            late <= 1'b1;
         else if (ph == PW'(1) && count == C_LRHB)
            late <= 1'b0;
      end
   end

endmodule

// File: tb/tb_tia_horiz_counter.sv
// Bench for tia_horiz_counter: line-position model checked every cycle, plus
// directed pulse-width, period, HMOVE and RSYNC scenarios.
module tb_tia_horiz_counter;

   logic       clk   = 1'b0;
   logic       rl    = 1'b0;
   logic       rsyn  = 1'b0;
   logic       hmove = 1'b0;
   logic       phi1, phi2;
   logic [5:0] count;
   logic       shb, shs, rhs, rcb, rhb, lrhb, cnt, res;
   logic       hsync, hblank;

   always #5 clk = ~clk;

   tia_horiz_counter dut (
      .clk(clk), .rl(rl), .rsyn(rsyn), .hmove(hmove),
      .phi1(phi1), .phi2(phi2), .count(count),
      .shb(shb), .shs(shs), .rhs(rhs), .rcb(rcb), .rhb(rhb), .lrhb(lrhb),
      .cnt(cnt), .res(res), .hsync(hsync), .hblank(hblank)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Code table built from the stepping rule: code[n] is the state n steps after 0.
   logic [5:0] code [57];
   function automatic logic [5:0] step_rule(input logic [5:0] c);
      return {c[4:0], ~(c[5] ^ c[4])};
   endfunction

   // Model: clocks since the last restart, the late flag, and this line's HBLANK hold.
   int t      = 0;
   bit late_m = 1'b0;
   bit held_m = 1'b0;
   bit valid  = 1'b0;

   always @(posedge clk) begin
      if (!rl) begin
         t = 0; late_m = 1'b0; held_m = 1'b0; valid = 1'b1;
      end else if (rsyn) begin
         t = 0; late_m = late_m | hmove; held_m = 1'b0;
      end else begin
         if ((t % 228) == 65) held_m = late_m | hmove;
         if (hmove) late_m = 1'b1;
         else if ((t % 228) == 73) late_m = 1'b0;
         t++;
      end
   end

   int   mp, mn;
   logic ehb;
   always @(negedge clk) begin
      if (valid) begin
         mp  = t % 228;
         mn  = (t / 4) % 57;
         ehb = (mp >= 2 || t < 228) && (mp < 66 || (held_m && mp < 74));
         chk("count",  32'(count),  32'(code[mn]));
         chk("phi1",   32'(phi1),   32'((t % 4) == 1));
         chk("phi2",   32'(phi2),   32'((t % 4) == 3));
         chk("shb",    32'(shb),    32'(mn == 0));
         chk("shs",    32'(shs),    32'(mn == 4));
         chk("rhs",    32'(rhs),    32'(mn == 8));
         chk("rcb",    32'(rcb),    32'(mn == 12));
         chk("rhb",    32'(rhb),    32'(mn == 16));
         chk("lrhb",   32'(lrhb),   32'(mn == 18));
         chk("cnt",    32'(cnt),    32'(mn == 36));
         chk("res",    32'(res),    32'(mn == 56));
         chk("hsync",  32'(hsync),  32'(mp >= 18 && mp < 34));
         chk("hblank", 32'(hblank), 32'(ehb));
      end
   end

   // Length of the most recently completed HBLANK high run.
   int hb_run  = 0;
   int hb_last = 0;
   always @(negedge clk) begin
      if (hblank === 1'b1) hb_run++;
      else if (hb_run != 0) begin
         hb_last = hb_run;
         hb_run  = 0;
      end
   end

   function automatic logic sig(input int k);
      case (k)
         0:       return shb;
         1:       return res;
         2:       return hsync;
         default: return hblank;
      endcase
   endfunction

   // Samples (one per negedge) until signal k reaches lvl.
   task automatic cycles_until(input int k, input logic lvl, output int n);
      n = 0;
      while (sig(k) !== lvl && n < 600) begin
         n++;
         @(negedge clk);
      end
      if (n >= 600) chk("wait_timeout", 32'(n), 32'd0);
   endtask

   // Drive hmove for exactly the edge that ends phi1 of code[step].
   task automatic pulse_hmove(input int step);
      int n;
      n = 0;
      while (!(count == code[step] && phi1 === 1'b1) && n < 600) begin
         n++;
         @(negedge clk);
      end
      if (n >= 600) chk("hmove_wait_timeout", 32'(n), 32'd0);
      hmove = 1'b1;
      @(negedge clk);
      hmove = 1'b0;
   endtask

   // Phase/counter sequence for the four clocks after a restart edge.
   task automatic post_restart();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk("restart_phi1",  32'(phi1),  32'(k == 1));
         chk("restart_phi2",  32'(phi2),  32'(k == 3));
         chk("restart_count", 32'(count), (k == 4) ? 32'd1 : 32'd0);
      end
   endtask

   bit seen [64];
   int n, w, distinct, bad;

   initial begin
      code[0] = '0;
      for (int i = 1; i < 57; i++) code[i] = step_rule(code[i-1]);
      chk("pin_c4",  32'(code[4]),  32'(6'b001111));
      chk("pin_c8",  32'(code[8]),  32'(6'b111011));
      chk("pin_c16", 32'(code[16]), 32'(6'b001110));
      chk("pin_c18", 32'(code[18]), 32'(6'b111010));

      // Reset held 3 clocks with hmove high.
      rl = 1'b0; hmove = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_phi1",   32'(phi1),   32'd0);
      chk("rst_phi2",   32'(phi2),   32'd0);
      chk("rst_count",  32'(count),  32'd0);
      chk("rst_hblank", 32'(hblank), 32'd1);
      chk("rst_hsync",  32'(hsync),  32'd0);
      chk("rst_shb",    32'(shb),    32'd1);
      rl = 1'b1; hmove = 1'b0;
      post_restart();

      // Free run: each line visits 57 distinct codes and never 111111.
      for (int l = 0; l < 3; l++) begin
         for (int i = 0; i < 64; i++) seen[i] = 1'b0;
         distinct = 0; bad = 0;
         for (int c = 0; c < 228; c++) begin
            @(negedge clk);
            if (!seen[count]) distinct++;
            seen[count] = 1'b1;
            if (count == 6'b111111) bad++;
         end
         chk("line_states", 32'(distinct), 32'd57);
         chk("never_3f",    32'(bad),      32'd0);
      end

      // shb width and period, res-to-shb spacing.
      cycles_until(0, 1'b0, n);
      cycles_until(0, 1'b1, n);
      cycles_until(0, 1'b0, w);
      chk("shb_width", 32'(w), 32'd4);
      cycles_until(0, 1'b1, n);
      chk("shb_period", 32'(w + n), 32'd228);
      cycles_until(1, 1'b1, n);
      cycles_until(1, 1'b0, w);
      chk("res_width",  32'(w),   32'd4);
      chk("res_to_shb", 32'(shb), 32'd1);

      // Levels, measured from the start of shb.
      cycles_until(2, 1'b1, n);
      chk("hsync_offset", 32'(n), 32'd18);
      cycles_until(2, 1'b0, w);
      chk("hsync_width", 32'(w), 32'd16);
      cycles_until(3, 1'b0, n);
      cycles_until(3, 1'b1, n);
      chk("hblank_low", 32'(n), 32'd164);
      cycles_until(3, 1'b0, w);
      chk("hblank_high", 32'(w), 32'd64);

      // HMOVE mid-blank: late line, then a normal one.
      pulse_hmove(10);
      chk("count_at_c10", 32'(count), 32'(6'b101111));
      cycles_until(3, 1'b0, n);
      #1;
      chk("hblank_late_c10", 32'(hb_last), 32'd72);
      chk("late_fall_code",  32'(count),   32'(6'b111010));
      cycles_until(3, 1'b1, n);
      cycles_until(3, 1'b0, n);
      #1;
      chk("hblank_after_late", 32'(hb_last), 32'd64);

      // HMOVE on the C16 decision edge still holds blanking.
      pulse_hmove(16);
      cycles_until(3, 1'b0, n);
      #1;
      chk("hblank_hmove_c16", 32'(hb_last), 32'd72);

      // HMOVE on the C18 edge survives the clear and lengthens the next line.
      pulse_hmove(18);
      cycles_until(3, 1'b1, n);
      cycles_until(3, 1'b0, n);
      #1;
      chk("hblank_hmove_c18", 32'(hb_last), 32'd72);

      // RSYNC at C30, with hmove on the same edge marking the new line late.
      n = 0;
      while (count != code[30] && n < 600) begin
         n++;
         @(negedge clk);
      end
      if (n >= 600) chk("c30_wait_timeout", 32'(n), 32'd0);
      rsyn = 1'b1; hmove = 1'b1;
      @(negedge clk);
      rsyn = 1'b0; hmove = 1'b0;
      chk("rsyn_count",  32'(count),  32'd0);
      chk("rsyn_hsync",  32'(hsync),  32'd0);
      chk("rsyn_hblank", 32'(hblank), 32'd1);
      chk("rsyn_phi1",   32'(phi1),   32'd0);
      chk("rsyn_phi2",   32'(phi2),   32'd0);
      post_restart();
      // Late line: hblank falls 74 clk after the restart edge; 4 already elapsed.
      cycles_until(3, 1'b0, n);
      chk("rsyn_late_hblank", 32'(n), 32'd70);

      repeat (300) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
